// File: rtl/wb_trace_pkg.sv
// Shared types for the write-back trace buffer: capture FSM state encodings.
package wb_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_POST = 3'd2,
    ST_DONE = 3'd3
  } state_e;

endpackage

// File: rtl/trace_ram.sv
// DEPTH x W trace storage, one write port and one registered read port; read data is valid the cycle after re_i.
module trace_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; array contents are don't-care after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Circular trace of register-file writes with trigger and post-trigger window, drained by a pop port.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle timestamp with each entry; otherwise rd_ts is 0.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [REG_AW-1:0]        trig_reg,
  input  logic                     wb_we,
  input  logic [REG_AW-1:0]        wb_rdest,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [REG_AW-1:0]        rd_rdest,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [2:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry layout depends on module parameters, so it is declared here rather than in the package.
`ifdef TRACE_TIMESTAMP_EN
  typedef struct packed {
    logic [REG_AW-1:0] rdest;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } entry_t;
`else
  typedef struct packed {
    logic [REG_AW-1:0] rdest;
    logic [DATA_W-1:0] data;
  } entry_t;
`endif

  state_e          state_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, post_cnt_q;
  logic            ovf_q, rd_valid_q;
  logic            is_event, wr_en, rd_en, full, hit;
  entry_t          wr_ent, rd_ent;
  logic [$bits(entry_t)-1:0] rd_bits;

  assign is_event = wb_we && (wb_rdest != '0);
  assign wr_en    = is_event && !arm && (state_q == ST_PRE || state_q == ST_POST);
  assign rd_en    = rd_req && !arm && (state_q == ST_DONE) && (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  assign hit      = trig_en && (wb_rdest == trig_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (arm) begin
        state_q  <= ST_PRE;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (full) rd_ptr_q <= rd_ptr_q + 1'b1;
          else      count_q  <= count_q + 1'b1;
        end
        if (rd_en) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          count_q  <= count_q - 1'b1;
        end
        case (state_q)
          ST_PRE: if (wr_en) begin
            if (full) ovf_q <= 1'b1;
            if (hit) begin
              post_cnt_q <= CW'(POST_TRIG);
              state_q    <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
            end else if (!trig_en && count_q == CW'(DEPTH - 1)) begin
              state_q <= ST_DONE;
            end
          end
          ST_POST: if (wr_en) begin
            post_cnt_q <= post_cnt_q - 1'b1;
            if (post_cnt_q == CW'(1)) state_q <= ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end
  assign wr_ent.ts = ts_q;
  assign rd_ts     = rd_ent.ts;
`else
  assign rd_ts = '0;
`endif

  assign wr_ent.rdest = wb_rdest;
  assign wr_ent.data  = wb_data;

  trace_ram #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_ent),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_bits)
  );

  assign rd_ent   = rd_bits;
  assign rd_rdest = rd_ent.rdest;
  assign rd_data  = rd_ent.data;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign state    = state_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: two instances (POST_TRIG=2 and POST_TRIG=0) share all inputs.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset, arm, trig_en, wb_we, rd_req;
  logic [4:0]  trig_reg, wb_rdest;
  logic [31:0] wb_data;

  logic        rd_valid_a, overflow_a, rd_valid_b, overflow_b;
  logic [4:0]  rd_rdest_a, count_a, rd_rdest_b, count_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic [15:0] rd_ts_a, rd_ts_b;
  logic [2:0]  state_a, state_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_ts;
  int exp_idx;
  logic [4:0] exp_r;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DATA_W(32), .REG_AW(5), .DEPTH(16), .TS_W(16), .POST_TRIG(2)) u_a (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_reg(trig_reg),
    .wb_we(wb_we), .wb_rdest(wb_rdest), .wb_data(wb_data), .rd_req(rd_req),
    .rd_valid(rd_valid_a), .rd_rdest(rd_rdest_a), .rd_data(rd_data_a), .rd_ts(rd_ts_a),
    .count(count_a), .overflow(overflow_a), .state(state_a)
  );

  wb_trace_buffer #(.DATA_W(32), .REG_AW(5), .DEPTH(16), .TS_W(16), .POST_TRIG(0)) u_b (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_reg(trig_reg),
    .wb_we(wb_we), .wb_rdest(wb_rdest), .wb_data(wb_data), .rd_req(rd_req),
    .rd_valid(rd_valid_b), .rd_rdest(rd_rdest_b), .rd_data(rd_data_b), .rd_ts(rd_ts_b),
    .count(count_b), .overflow(overflow_b), .state(state_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [4:0] r, input logic [31:0] d);
    wb_we    = 1'b1;
    wb_rdest = r;
    wb_data  = d;
    tick();
    wb_we    = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; trig_en = 1'b0; wb_we = 1'b0; rd_req = 1'b0;
    trig_reg = '0; wb_rdest = '0; wb_data = '0;
    #2;
    chk("rst_state", state_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_ovf", overflow_a, 0);
    chk("rst_valid", rd_valid_a, 0);
    chk("rst_rdest", rd_rdest_a, 0);
    chk("rst_data", rd_data_a, 0);
    chk("rst_ts", rd_ts_a, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Arm, ignored read in PRE, R0 write never recorded or triggering, then async reset mid-capture
    do_arm();
    chk("arm_state", state_a, 1);
    chk("arm_count", count_a, 0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("pre_rdreq_ignored", rd_valid_a, 0);
    trig_en = 1'b1; trig_reg = 5'd0;
    ev(5'd0, 32'hdead);
    chk("r0_count", count_a, 0);
    chk("r0_no_trig_a", state_a, 1);
    chk("r0_no_trig_b", state_b, 1);
    trig_en = 1'b0;
    ev(5'd1, 32'h1); ev(5'd2, 32'h2); ev(5'd3, 32'h3);
    chk("pre3_count", count_a, 3);
    #2 reset = 1'b1;
    #1;
    chk("midrst_state", state_a, 0);
    chk("midrst_count", count_a, 0);
    chk("midrst_ovf", overflow_a, 0);
    chk("midrst_valid", rd_valid_a, 0);
    #1 reset = 1'b0;
    tick();

    // Capture until full without trigger
    trig_en = 1'b0;
    do_arm();
    for (int i = 1; i <= 20; i++) begin
      ev(5'(i), 32'h100 + 32'(i));
      if (i == 15) begin
        chk("full15_state", state_a, 1);
        chk("full15_count", count_a, 15);
      end
      if (i == 16) begin
        chk("full16_state", state_a, 3);
        chk("full16_count", count_a, 16);
      end
    end
    chk("full_end_count", count_a, 16);
    chk("full_end_state", state_a, 3);
    chk("full_no_ovf", overflow_a, 0);
    rd_req = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      tick();
      if (j <= 16) begin
        chk("full_pop_valid", rd_valid_a, 1);
        chk("full_pop_rdest", rd_rdest_a, 64'(j));
        chk("full_pop_data", rd_data_a, 64'h100 + 64'(j));
`ifdef TRACE_TIMESTAMP_EN
        if (j > 1) chk("full_pop_ts_inc", rd_ts_a > prev_ts, 1);
        prev_ts = rd_ts_a;
`else
        chk("full_pop_ts_zero", rd_ts_a, 0);
`endif
      end else begin
        chk("full_pop17_valid", rd_valid_a, 0);
      end
    end
    rd_req = 1'b0;
    chk("full_drained_count", count_a, 0);

    // Triggered capture with wrap: R7 is the 18th event, two post-trigger events
    trig_en = 1'b1; trig_reg = 5'd7;
    do_arm();
    for (int i = 1; i <= 20; i++) begin
      ev((i == 18) ? 5'd7 : 5'(i + 8), 32'h200 + 32'(i));
      if (i == 16) chk("trig16_ovf", overflow_a, 0);
      if (i == 17) begin
        chk("trig17_ovf", overflow_a, 1);
        chk("trig17_state", state_a, 1);
      end
      if (i == 18) chk("trig18_state", state_a, 2);
      if (i == 19) chk("trig19_state", state_a, 2);
    end
    chk("trig_done_state", state_a, 3);
    chk("trig_done_count", count_a, 16);
    chk("trig_done_ovf", overflow_a, 1);
    rd_req = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      tick();
      exp_idx = j + 4;
      exp_r   = (exp_idx == 18) ? 5'd7 : 5'(exp_idx + 8);
      chk("trig_pop_valid", rd_valid_a, 1);
      chk("trig_pop_rdest", rd_rdest_a, 64'(exp_r));
      chk("trig_pop_data", rd_data_a, 64'h200 + 64'(exp_idx));
`ifdef TRACE_TIMESTAMP_EN
      if (j > 1) chk("trig_pop_ts_inc", rd_ts_a > prev_ts, 1);
      prev_ts = rd_ts_a;
`else
      chk("trig_pop_ts_zero", rd_ts_a, 0);
`endif
    end
    rd_req = 1'b0;
    chk("trig_drained_count", count_a, 0);

    // POST_TRIG=0: the trigger as the first event finishes capture at once
    do_arm();
    ev(5'd7, 32'd3);
    chk("pt0_state", state_b, 3);
    chk("pt0_count", count_b, 1);
    chk("pt2_post_state", state_a, 2);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("pt0_pop_valid", rd_valid_b, 1);
    chk("pt0_pop_rdest", rd_rdest_b, 7);
    chk("pt0_pop_data", rd_data_b, 3);
    chk("pt0_pop_count", count_b, 0);
    chk("post_rdreq_ignored", rd_valid_a, 0);

    // arm + rd_req (+ event) together in DONE with count=5
    do_arm();
    ev(5'd10, 32'ha); ev(5'd11, 32'hb); ev(5'd12, 32'hc); ev(5'd13, 32'hd);
    ev(5'd7, 32'he);
    chk("arm_rd_pre_state", state_b, 3);
    chk("arm_rd_pre_count", count_b, 5);
    arm = 1'b1; rd_req = 1'b1;
    wb_we = 1'b1; wb_rdest = 5'd9; wb_data = 32'h99;
    tick();
    arm = 1'b0; rd_req = 1'b0; wb_we = 1'b0;
    chk("arm_rd_state", state_b, 1);
    chk("arm_rd_count", count_b, 0);
    chk("arm_rd_valid", rd_valid_b, 0);
    chk("arm_event_dropped", count_a, 0);
    tick();
    chk("arm_rd_valid_after", rd_valid_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
